// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - multi-cycle IEEE-754 single-precision divider, restoring radix-2
module fdiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        ready,
    output logic        done,
    output logic [31:0] y
);
    typedef enum logic [1:0] {IDLE, PREP, DIV, ROUND} state_t;

    state_t             state;
    logic [31:0]        a;
    logic [31:0]        b;
    logic [23:0]        mb;
    logic [24:0]        rem;
    logic [24:0]        q;
    logic signed [9:0]  e;
    logic [4:0]         cnt;

    logic [23:0]        ma_c;
    logic [23:0]        mb_c;
    logic               shift_c;
    logic signed [9:0]  e_c;
    logic               ge;
    logic [23:0]        diff;
    logic               sign;
    logic               za;
    logic               zb;
    logic               inc;
    logic               carry;
    logic [22:0]        mf;
    logic signed [9:0]  ef;
    logic [31:0]        y_c;

    assign ma_c    = {1'b1, a[22:0]};
    assign mb_c    = {1'b1, b[22:0]};
    assign shift_c = ma_c < mb_c;
    assign e_c     = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
                   + 10'sd127 - (shift_c ? 10'sd1 : 10'sd0);

    // Remainder stays below 2*mb, so the difference always fits in 24 bits.
    assign ge   = rem >= {1'b0, mb};
    assign diff = ge ? 24'(rem - {1'b0, mb}) : rem[23:0];

    assign sign  = a[31] ^ b[31];
    assign za    = a[30:23] == 8'd0;
    assign zb    = b[30:23] == 8'd0;
    assign inc   = q[0] & ((rem != 25'd0) | q[1]);
    assign carry = inc & (&q[24:1]);
    assign mf    = q[23:1] + {22'd0, inc};
    assign ef    = carry ? e + 10'sd1 : e;

    always_comb begin
        y_c = {sign, ef[7:0], mf};
        if (za && zb)
            y_c = 32'h7FC00000;
        else if (zb)
            y_c = {sign, 8'hFF, 23'h0};
        else if (za)
            y_c = {sign, 31'h0};
        else if (ef >= 10'sd255)
            y_c = {sign, 8'hFF, 23'h0};
        else if (ef <= 10'sd0)
            y_c = {sign, 31'h0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            y     <= 32'h0;
            cnt   <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        a     <= x1;
                        b     <= x2;
                        ready <= 1'b0;
                        state <= PREP;
                    end
                end
                PREP: begin
                    rem   <= shift_c ? {ma_c, 1'b0} : {1'b0, ma_c};
                    mb    <= mb_c;
                    e     <= e_c;
                    q     <= 25'd0;
                    cnt   <= 5'd0;
                    state <= DIV;
                end
                DIV: begin
                    rem <= {diff, 1'b0};
                    q   <= {q[23:0], ge};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd24)
                        state <= ROUND;
                end
                ROUND: begin
                    y     <= y_c;
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb/tb_fdiv_seq.sv - directed and swept checks for fdiv_seq
module tb_fdiv_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        ready;
    logic        done;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fdiv_seq dut (
        .clk(clk), .rst(rst), .req(req), .x1(x1), .x2(x2),
        .ready(ready), .done(done), .y(y)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact double-precision quotient rounded once more to single (innocuous for division).
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [63:0] da;
        logic [63:0] db;
        logic [63:0] dq;
        real         r;
        int          se;
        logic        rinc;
        logic [24:0] mm;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return 32'h7FC00000;
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'h0};
        if (a[30:23] == 8'd0) return {s, 31'h0};
        da = {1'b0, {3'b000, a[30:23]} + 11'd896, a[22:0], 29'd0};
        db = {1'b0, {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
        r  = $bitstoreal(da) / $bitstoreal(db);
        dq = $realtobits(r);
        se = int'(dq[62:52]) - 896;
        rinc = dq[28] & ((|dq[27:0]) | dq[29]);
        mm = {2'b01, dq[51:29]} + {24'd0, rinc};
        if (mm[24]) se++;
        if (se >= 255) return {s, 8'hFF, 23'h0};
        if (se <= 0) return {s, 31'h0};
        return {s, 8'(se), mm[22:0]};
    endfunction

    function automatic logic [22:0] pick_man();
        case ($urandom_range(0, 4))
            0: return 23'h000000;
            1: return 23'h000001;
            2: return 23'h7FFFFF;
            3: return 23'h400000;
            default: return 23'($urandom);
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        for (int w = 0; w < 60 && !ready; w++) @(negedge clk);
        check({tag, " ready_wait"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int k;
        int busy_high;
        wait_ready(tag);
        req = 1'b1;
        x1  = a;
        x2  = b;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        x1  = $urandom;
        x2  = $urandom;
        check({tag, " ready_low"}, {31'd0, ready}, 32'd0);
        k = 0;
        busy_high = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            if (!done && ready) busy_high++;
        end
        check({tag, " latency"}, k, 27);
        check({tag, " busy_ready"}, busy_high, 0);
        check({tag, " y"}, y, exp);
        check({tag, " ready_at_done"}, {31'd0, ready}, 32'd1);
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " y_hold"}, y, exp);
    endtask

    initial begin
        int k;
        int dones;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1;
        req = 1'b0;
        x1  = 32'h0;
        x2  = 32'h0;
        repeat (2) @(negedge clk);
        check("reset ready", {31'd0, ready}, 32'd1);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset y", y, 32'h0);
        rst = 1'b0;

        do_op(32'h40C00000, 32'h40000000, 32'h40400000, "six_by_two");
        do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "third");
        do_op(32'hBF800000, 32'h40400000, 32'hBEAAAAAB, "neg_third");
        do_op(32'h3F800000, 32'h00000000, 32'h7F800000, "div_zero");
        do_op(32'h00000000, 32'h00000000, 32'h7FC00000, "zero_zero");
        do_op(32'h80000000, 32'h40400000, 32'h80000000, "neg_zero_num");
        do_op(32'h7F000000, 32'h00800000, 32'h7F800000, "overflow");
        do_op(32'h00800000, 32'h40000000, 32'h00000000, "underflow");
        do_op(32'h80800000, 32'h40000000, 32'h80000000, "neg_underflow");

        // req held high: a new accept lands on each done cycle.
        wait_ready("hold");
        req = 1'b1;
        x1  = 32'h40C00000;
        x2  = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        k = 0;
        while (!done && k < 40) begin @(negedge clk); k++; end
        check("hold first latency", k, 27);
        check("hold first y", y, 32'h40400000);
        x1 = 32'h3F800000;
        x2 = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        check("hold reaccept ready", {31'd0, ready}, 32'd0);
        k = 0;
        while (!done && k < 40) begin @(negedge clk); k++; end
        check("hold second latency", k, 27);
        check("hold second y", y, 32'h3EAAAAAB);
        req = 1'b0;
        @(negedge clk);
        check("hold released ready", {31'd0, ready}, 32'd1);

        // Reset while DIV is on iteration 10 discards the operation.
        wait_ready("mid_reset");
        req = 1'b1;
        x1  = 32'h40C00000;
        x2  = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset ready", {31'd0, ready}, 32'd1);
        check("mid_reset y", y, 32'h0);
        check("mid_reset done", {31'd0, done}, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_reset no_done", dones, 0);

        for (int i = 0; i < 40; i++) begin
            if (i < 24) begin
                ra = {1'($urandom), 8'($urandom_range(100, 154)), pick_man()};
                rb = {1'($urandom), 8'($urandom_range(100, 154)), pick_man()};
            end else begin
                ra = {1'($urandom), 8'($urandom_range(1, 254)), pick_man()};
                rb = {1'($urandom), 8'($urandom_range(1, 254)), pick_man()};
            end
            do_op(ra, rb, ref_div(ra, rb), $sformatf("sweep%0d %h/%h", i, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
